// File: rtl/prefix_adder_pipe_if.sv
// ---------------------------------------------------------------------------
// prefix_adder_pipe_if
// Handshake and data bundle for prefix_adder_pipe.
//   in_valid / in_ready      : operand handshake (master -> adder)
//   a, b, cin, approx_k      : operands, carry-in, approximate-lower-part size
//   out_valid / out_ready    : result handshake (adder -> master)
//   sum, cout                : result and carry-out
// The adder connects through the slave modport; the producer/consumer side
// uses master.
// ---------------------------------------------------------------------------
interface prefix_adder_pipe_if #(
    parameter int WIDTH      = 16,
    parameter int APPROX_MAX = 8
);
    localparam int KW = $clog2(APPROX_MAX + 1);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic [KW-1:0]    approx_k;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport slave (
        input  in_valid, a, b, cin, approx_k, out_ready,
        output in_ready, out_valid, sum, cout
    );

    modport master (
        output in_valid, a, b, cin, approx_k, out_ready,
        input  in_ready, out_valid, sum, cout
    );
endinterface

// File: rtl/prefix_adder_pipe.sv
// ---------------------------------------------------------------------------
// prefix_adder_pipe
// Pipelined Kogge-Stone adder with an OR-based approximate lower part.
//   clk    : clock, rising edge
//   rst_n  : synchronous active-low reset
//   bus    : prefix_adder_pipe_if.slave (operand/result handshakes)
// Pipeline: pg stage, LEVELS prefix levels, output stage (latency LEVELS+2).
// A single global stall freezes every stage while a result waits downstream.
// ---------------------------------------------------------------------------
module prefix_adder_pipe #(
    parameter int WIDTH      = 16,
    parameter int APPROX_MAX = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    prefix_adder_pipe_if.slave    bus
);
    localparam int LEVELS = $clog2(WIDTH);
    localparam int KW     = $clog2(APPROX_MAX + 1);

    // -------------------------------------------------------------------
    // Flow control
    // -------------------------------------------------------------------
    logic w_adv;
    logic r_out_valid;

    assign w_adv        = !r_out_valid || bus.out_ready;
    assign bus.in_ready = w_adv;

    // -------------------------------------------------------------------
    // Stage 0: clamp k, generate/propagate with lower-part masking
    // -------------------------------------------------------------------
    logic [KW-1:0]    w_k;
    logic             w_cin;
    logic [WIDTH-1:0] w_g0;
    logic [WIDTH-1:0] w_p0;
    logic [WIDTH-1:0] w_praw0;
    logic [WIDTH-1:0] w_or0;

    assign w_k     = (32'(bus.approx_k) > 32'(APPROX_MAX)) ? KW'(APPROX_MAX) : bus.approx_k;
    // cin only participates in exact operations
    assign w_cin   = bus.cin && (w_k == '0);
    assign w_praw0 = bus.a ^ bus.b;
    assign w_or0   = bus.a | bus.b;

    genvar gi, gj;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_pg
            logic w_low;
            logic w_inj;
            logic w_gen;
            assign w_low = 32'(gi) < 32'(w_k);
            // the approximate part hands its carry in as a generate at bit k-1
            assign w_inj = (32'(gi) + 32'd1) == 32'(w_k);
            assign w_gen = bus.a[gi] & bus.b[gi];
            if (gi == 0) begin : g_lsb
                // extra LSB cell: fold cin (position -1) into bit 0
                assign w_g0[gi] = w_low ? (w_inj & w_gen)
                                        : (w_gen | (w_praw0[gi] & w_cin));
            end else begin : g_mid
                assign w_g0[gi] = w_low ? (w_inj & w_gen) : w_gen;
            end
            assign w_p0[gi] = ~w_low & w_praw0[gi];
        end
    endgenerate

    // -------------------------------------------------------------------
    // Pipeline registers: index 0 is the pg stage, 1..LEVELS prefix levels
    // -------------------------------------------------------------------
    logic [LEVELS:0][WIDTH-1:0] r_g;
    logic [WIDTH-1:0]           r_p [0:LEVELS];
    logic [LEVELS:0][WIDTH-1:0] r_praw;
    logic [LEVELS:0][WIDTH-1:0] r_or;
    logic [KW-1:0]              r_k [0:LEVELS];
    logic [LEVELS:0]            r_cin;
    logic [LEVELS:0]            r_vld;

    // -------------------------------------------------------------------
    // Prefix levels: level gi pairs position gj with gj - 2^(gi-1)
    // -------------------------------------------------------------------
    logic [LEVELS:1][WIDTH-1:0] w_lg;
    logic [LEVELS:1][WIDTH-1:0] w_lp;

    generate
        for (gi = 1; gi <= LEVELS; gi++) begin : g_lvl
            localparam int D = 1 << (gi - 1);
            for (gj = 0; gj < WIDTH; gj++) begin : g_bit
                if (gj >= D) begin : g_cell
                    assign w_lg[gi][gj] = r_g[gi-1][gj] | (r_g[gi-1][gj-D] & r_p[gi-1][gj]);
                    assign w_lp[gi][gj] = r_p[gi-1][gj] & r_p[gi-1][gj-D];
                end else begin : g_pass
                    assign w_lg[gi][gj] = r_g[gi-1][gj];
                    assign w_lp[gi][gj] = r_p[gi-1][gj];
                end
            end
        end
    endgenerate

    // Datapath registers need no reset: their validity travels in r_vld
    always_ff @(posedge clk) begin
        if (w_adv) begin
            r_g[0]    <= w_g0;
            r_p[0]    <= w_p0;
            r_praw[0] <= w_praw0;
            r_or[0]   <= w_or0;
            r_k[0]    <= w_k;
            for (int s = 1; s <= LEVELS; s++) begin
                r_g[s]    <= w_lg[s];
                r_p[s]    <= w_lp[s];
                r_praw[s] <= r_praw[s-1];
                r_or[s]   <= r_or[s-1];
                r_k[s]    <= r_k[s-1];
            end
            r_cin <= {r_cin[LEVELS-1:0], w_cin};
        end
    end

    // -------------------------------------------------------------------
    // Final stage: sum bits from raw p and group generates
    // -------------------------------------------------------------------
    logic [WIDTH-1:0] w_carry;
    logic [WIDTH-1:0] w_sum;
    logic             w_cout;

    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_sum
            logic w_lowf;
            assign w_lowf = 32'(gi) < 32'(r_k[LEVELS]);
            if (gi == 0) begin : g_c0
                assign w_carry[gi] = r_cin[LEVELS];
            end else begin : g_cn
                assign w_carry[gi] = r_g[LEVELS][gi-1];
            end
            assign w_sum[gi] = w_lowf ? r_or[LEVELS][gi] : (r_praw[LEVELS][gi] ^ w_carry[gi]);
        end
    endgenerate

    assign w_cout = r_g[LEVELS][WIDTH-1];

    // -------------------------------------------------------------------
    // Valid chain and output registers
    // -------------------------------------------------------------------
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_vld       <= '0;
            r_out_valid <= 1'b0;
            r_sum       <= '0;
            r_cout      <= 1'b0;
        end else if (w_adv) begin
            r_vld       <= {r_vld[LEVELS-1:0], bus.in_valid};
            r_out_valid <= r_vld[LEVELS];
            r_sum       <= w_sum;
            r_cout      <= w_cout;
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.sum       = r_sum;
    assign bus.cout      = r_cout;
endmodule

// File: tb/tb_prefix_adder_pipe.sv
// ---------------------------------------------------------------------------
// tb_prefix_adder_pipe
// Drives a WIDTH=16/APPROX_MAX=8 instance (directed table, random streaming,
// random backpressure, reset while stalled) and a WIDTH=4/APPROX_MAX=2
// instance (exhaustive). Expected results are queued at acceptance and
// compared when the adder presents them.
// ---------------------------------------------------------------------------
module tb_prefix_adder_pipe;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    prefix_adder_pipe_if #(.WIDTH(16), .APPROX_MAX(8)) bus1 ();
    prefix_adder_pipe_if #(.WIDTH(4),  .APPROX_MAX(2)) bus2 ();

    prefix_adder_pipe #(.WIDTH(16), .APPROX_MAX(8)) dut16 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    prefix_adder_pipe #(.WIDTH(4), .APPROX_MAX(2)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2)
    );

    int checks   = 0;
    int failures = 0;

    // golden model: returns {cout, sum} masked to w+1 bits
    function automatic logic [16:0] model(input int w, input int amax, input int a,
                                          input int b, input int cin, input int k);
        int ke;
        int r;
        int c;
        ke = (k > amax) ? amax : k;
        if (ke == 0) begin
            r = a + b + cin;
        end else begin
            c = ((a >> (ke - 1)) & 1) & ((b >> (ke - 1)) & 1);
            r = ((((a >> ke) + (b >> ke) + c) << ke)) | ((a | b) & ((1 << ke) - 1));
        end
        r = r & ((1 << (w + 1)) - 1);
        return 17'(r);
    endfunction

    typedef struct {
        logic [16:0] res;
        int          t0;
        int          st0;
    } sb_t;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic [3:0]  k;
        logic [16:0] exp;
    } vec_t;

    sb_t         sb1 [$];
    logic [4:0]  sb2 [$];
    sb_t         mon_e;
    logic [16:0] cur_exp1 = '0;
    logic [16:0] m2;
    int          cyc = 0;
    int          stalls1 = 0;
    int          wd = 0;
    int          txn1 = 0;
    int          txn2 = 0;
    bit          seen1 = 0;
    bit          rst_seen = 0;
    bit          end_req = 0;
    bit          end_done = 0;
    int          ready_mode = 1;   // 0: hold low, 1: hold high, 2: random

    always @(posedge clk) begin
        #1;
        bus1.out_ready = (ready_mode == 2) ? 1'($urandom_range(0, 1)) : (ready_mode == 1);
    end

    // -------------------------------------------------------------------
    // Monitor / scoreboard (samples on the falling edge)
    // -------------------------------------------------------------------
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            sb1.delete();
            sb2.delete();
            rst_seen = 1;
            seen1    = 0;
            wd       = 0;
        end else begin
            if (rst_seen) begin
                rst_seen = 0;
                checks++;
                if (bus1.out_valid !== 1'b0 || bus1.sum !== 16'h0 || bus1.cout !== 1'b0) begin
                    failures++;
                    $display("FAIL reset_state got valid=%b sum=%h cout=%b exp valid=0 sum=0000 cout=0",
                             bus1.out_valid, bus1.sum, bus1.cout);
                end
                checks++;
                if (bus1.in_ready !== 1'b1) begin
                    failures++;
                    $display("FAIL reset_in_ready got=%b exp=1", bus1.in_ready);
                end
            end

            checks++;
            if (bus1.in_ready !== (!bus1.out_valid || bus1.out_ready)) begin
                failures++;
                $display("FAIL in_ready_rule got=%b exp=%b", bus1.in_ready,
                         (!bus1.out_valid || bus1.out_ready));
            end

            if (bus1.out_valid) begin
                checks++;
                if (sb1.size() == 0) begin
                    failures++;
                    $display("FAIL dut16_unexpected got sum=%h cout=%b exp no result", bus1.sum, bus1.cout);
                end else begin
                    mon_e = sb1[0];
                    if (!seen1) begin
                        seen1 = 1;
                        checks++;
                        if (cyc - mon_e.t0 != 6 + stalls1 - mon_e.st0) begin
                            failures++;
                            $display("FAIL dut16_latency got=%0d exp=%0d", cyc - mon_e.t0,
                                     6 + stalls1 - mon_e.st0);
                        end
                    end
                    if ({bus1.cout, bus1.sum} !== mon_e.res) begin
                        failures++;
                        $display("FAIL dut16_result got=%h exp=%h", {bus1.cout, bus1.sum}, mon_e.res);
                    end
                    if (bus1.out_ready) begin
                        txn1++;
                        $display("txn dut16 #%0d result=%h", txn1, {bus1.cout, bus1.sum});
                        void'(sb1.pop_front());
                        seen1 = 0;
                    end
                end
            end
            if (bus1.out_valid && !bus1.out_ready) stalls1++;
            if (bus1.in_valid && bus1.in_ready) sb1.push_back('{cur_exp1, cyc, stalls1});

            if (bus1.in_valid && !bus1.in_ready) wd++;
            else wd = 0;
            if (wd == 64) begin
                checks++;
                failures++;
                $display("FAIL dut16_accept_timeout got stalled=%0d cycles exp<64", wd);
            end

            if (bus2.out_valid) begin
                checks++;
                if (sb2.size() == 0) begin
                    failures++;
                    $display("FAIL dut4_unexpected got=%h exp no result", {bus2.cout, bus2.sum});
                end else begin
                    txn2++;
                    if ({bus2.cout, bus2.sum} !== sb2[0]) begin
                        failures++;
                        $display("FAIL dut4_result got=%h exp=%h", {bus2.cout, bus2.sum}, sb2[0]);
                    end else begin
                        $display("txn dut4 #%0d result=%h", txn2, {bus2.cout, bus2.sum});
                    end
                    void'(sb2.pop_front());
                end
            end
            if (bus2.in_valid && bus2.in_ready) begin
                m2 = model(4, 2, int'(bus2.a), int'(bus2.b), int'(bus2.cin), int'(bus2.approx_k));
                sb2.push_back(m2[4:0]);
            end

            if (end_req && !end_done) begin
                end_done = 1;
                checks++;
                if (sb1.size() != 0 || sb2.size() != 0) begin
                    failures++;
                    $display("FAIL drain got pending16=%0d pending4=%0d exp 0 0", sb1.size(), sb2.size());
                end
            end
        end
    end

    // -------------------------------------------------------------------
    // Stimulus
    // -------------------------------------------------------------------
    task automatic send1(input logic [15:0] a, input logic [15:0] b, input logic cin,
                         input logic [3:0] k, input logic [16:0] exp);
        bus1.a        = a;
        bus1.b        = b;
        bus1.cin      = cin;
        bus1.approx_k = k;
        cur_exp1      = exp;
        bus1.in_valid = 1'b1;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (bus1.in_ready) begin
                @(posedge clk);
                #1;
                return;
            end
            @(posedge clk);
            #1;
        end
        bus1.in_valid = 1'b0;
    endtask

    vec_t vecs [9];

    initial begin
        logic [15:0] ra;
        logic [15:0] rb;
        logic        rc;
        logic [3:0]  rk;

        vecs[0] = '{16'hFFFF, 16'h0001, 1'b0, 4'd0,  17'h10000};
        vecs[1] = '{16'h1234, 16'h4321, 1'b1, 4'd0,  17'h05556};
        vecs[2] = '{16'h000F, 16'h0001, 1'b0, 4'd4,  17'h0000F};
        vecs[3] = '{16'h00F8, 16'h0008, 1'b0, 4'd4,  17'h00108};
        vecs[4] = '{16'h00FF, 16'h00FF, 1'b0, 4'd12, 17'h001FF};
        vecs[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 4'd0,  17'h1FFFF};
        vecs[6] = '{16'hFFFF, 16'h0080, 1'b1, 4'd8,  17'h100FF};
        vecs[7] = '{16'h0001, 16'h0001, 1'b1, 4'd1,  17'h00003};
        vecs[8] = '{16'h8000, 16'h8000, 1'b0, 4'd15, 17'h10000};

        bus1.in_valid = 1'b0;
        bus1.a = '0; bus1.b = '0; bus1.cin = 1'b0; bus1.approx_k = '0;
        bus2.in_valid = 1'b0;
        bus2.a = '0; bus2.b = '0; bus2.cin = 1'b0; bus2.approx_k = '0;
        bus2.out_ready = 1'b1;

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // directed table, back to back
        for (int i = 0; i < 9; i++)
            send1(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].k, vecs[i].exp);
        bus1.in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;

        // single op in an empty pipe, then a gap
        send1(16'h7FFF, 16'h0001, 1'b0, 4'd0, 17'h08000);
        bus1.in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;

        // streaming with mixed k
        for (int i = 0; i < 200; i++) begin
            ra = 16'($urandom); rb = 16'($urandom);
            rc = 1'($urandom_range(0, 1)); rk = 4'($urandom_range(0, 15));
            send1(ra, rb, rc, rk, model(16, 8, int'(ra), int'(rb), int'(rc), int'(rk)));
        end

        // random backpressure under full input load
        ready_mode = 2;
        for (int i = 0; i < 200; i++) begin
            ra = 16'($urandom); rb = 16'($urandom);
            rc = 1'($urandom_range(0, 1)); rk = 4'($urandom_range(0, 15));
            send1(ra, rb, rc, rk, model(16, 8, int'(ra), int'(rb), int'(rc), int'(rk)));
        end
        bus1.in_valid = 1'b0;
        ready_mode = 1;
        repeat (30) @(posedge clk);
        #1;

        // fill and stall the pipe, then reset it
        ready_mode = 0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 10; i++) begin
            ra = 16'($urandom); rb = 16'($urandom);
            rc = 1'($urandom_range(0, 1)); rk = 4'($urandom_range(0, 15));
            bus1.a = ra; bus1.b = rb; bus1.cin = rc; bus1.approx_k = rk;
            cur_exp1 = model(16, 8, int'(ra), int'(rb), int'(rc), int'(rk));
            bus1.in_valid = 1'b1;
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        ready_mode = 1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus1.in_valid = 1'b0;
        repeat (20) @(posedge clk);
        #1;

        // exhaustive small configuration
        for (int k = 0; k < 4; k++)
            for (int c = 0; c < 2; c++)
                for (int a = 0; a < 16; a++)
                    for (int b = 0; b < 16; b++) begin
                        bus2.a = 4'(a); bus2.b = 4'(b);
                        bus2.cin = 1'(c); bus2.approx_k = 2'(k);
                        bus2.in_valid = 1'b1;
                        @(posedge clk);
                        #1;
                    end
        bus2.in_valid = 1'b0;
        repeat (20) @(posedge clk);
        #1;

        end_req = 1;
        for (int t = 0; t < 10 && !end_done; t++) @(posedge clk);
        if (!end_done) begin
            failures++;
            checks++;
            $display("FAIL drain_check got not_run exp run");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/prefix_adder_pipe.md
# prefix_adder_pipe

Parametrised, pipelined Kogge-Stone parallel-prefix adder with a run-time accuracy control, for the approximate multiplier's final carry-propagate addition. Each prefix level is built from black/grey cell (G,P) combine operators and is registered, so one addition is accepted per cycle at high clock rates. A per-operation `approx_k` field replaces the low `k` bits with an OR-based lower-part approximation, trading accuracy for power. A valid/ready handshake provides backpressure toward the downstream accumulator.

## Interface
- `WIDTH`, 16: operand width; power of two, ≥4.
- `APPROX_MAX`, 8: largest honoured approximate-lower-part size; must be < `WIDTH`.
- `LEVELS`, derived = clog2(`WIDTH`): number of prefix levels. Not user-settable.
- `KW`, derived = clog2(`APPROX_MAX`+1): width of `approx_k`.
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `in_valid`  in  1  operands valid.
- `in_ready`  out  1  block can accept this cycle.
- `a`, `b`  in  `WIDTH`  unsigned operands.
- `cin`  in  1  carry-in; used only when effective k = 0.
- `approx_k`  in  `KW`  number of approximated LSBs for this operation.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  downstream accepts result.
- `sum`  out  `WIDTH`  result.
- `cout`  out  1  carry-out of bit `WIDTH`-1.

## Operation
- Effective k = min(`approx_k`, `APPROX_MAX`), captured with the operands and carried down the pipe; operations with different k may be in flight together.
- k = 0: exact, {cout,sum} = a + b + cin.
- k > 0: sum[k-1:0] = a[k-1:0] | b[k-1:0]; carry into bit k = a[k-1] & b[k-1]; bits k..`WIDTH`-1 and cout are the exact sum of upper operand bits plus that carry; cin ignored.
- Stage 0 (pg): g_i = a_i&b_i, p_i = a_i^b_i for bits ≥ k; bits < k forced to g=p=0 so they neither generate nor propagate, and the injected carry enters as g at position k-1 (cin as g at position −1 when k = 0, realised as an extra LSB cell).
- Stages 1..`LEVELS`: level L combines (G,P) at i with i−2^(L−1): G = G_hi | (G_lo & P_hi), P = P_hi & P_lo; positions below reach pass through. Each level registered, along with the raw p vector, the OR vector and k.
- Final stage: sum_i = p_i ^ G_(i−1) for i ≥ k, OR bits for i < k; cout = G_(`WIDTH`−1); registered to outputs.
- Flow control: single global stall. `in_ready` = !`out_valid` | `out_ready` (combinational). When `in_ready` = 0 every stage register, valid bit and output holds; when 1 the whole pipe advances and a bubble enters if `in_valid` = 0.
- An input is accepted iff `in_valid` & `in_ready` on a rising edge; `a`, `b`, `cin`, `approx_k` are don't-care otherwise.

## Timing
- Latency LAT = `LEVELS` + 2 cycles (6 at `WIDTH` = 16): accepted in cycle n → `out_valid` with its result in cycle n+LAT absent stalls; each stall cycle adds one.
- Throughput 1 op/cycle with `out_ready` held high; results emerge in acceptance order, no drops, no duplicates.
- Result holds stable while `out_valid` & !`out_ready`.
- Reset (`rst_n` low at a rising edge): all stage valid bits, `out_valid`, `sum`, `cout` → 0 from that edge; in-flight operations discarded, even mid-pipe or during a stall. `in_ready` = 1 in the first cycle after reset.
- `approx_k` > `APPROX_MAX` clamps silently; no error output.

## Test plan
- Exact wrap: k=0, a=0xFFFF, b=0x0001, cin=0 → after 6 cycles sum=0x0000, cout=1; a=0x1234, b=0x4321, cin=1 → sum=0x5556, cout=0.
- Approximate: k=4, a=0x000F, b=0x0001 → sum=0x000F, cout=0; k=4, a=0x00F8, b=0x0008 → sum=0x0108, cout=0; k=12 (clamped to 8), a=0x00FF, b=0x00FF → sum=0x01FF.
- Streaming: 200 back-to-back random ops with mixed k, `out_ready`=1 → one result per cycle, all match a golden model, order preserved.
- Backpressure: random `out_ready` toggling under full input load → `in_ready` tracks !`out_valid`|`out_ready`, held outputs stable, zero loss or duplication.
- Reset mid-stream: assert `rst_n`=0 with pipe full and stalled → next cycle `out_valid`=0, `sum`=0, `cout`=0; no stale result appears after release.
- Exhaustive small config `WIDTH`=4, `APPROX_MAX`=2: all a, b, cin, k combinations against the model.
